// File: rtl/ip_txn_requester_if.sv
// Signal bundle between a local core, one ip_txn_requester and its system-agent port.
// master = requester side, slave = core/agent side.
interface ip_txn_requester_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [15:0] rsp_addr;
  logic        rsp_err;
  logic        busy;
  logic [15:0] ip_addr;
  logic [5:0]  ip_req_trans;
  logic [31:0] ip_dat;
  logic [3:0]  ip_trans_id;

  modport master (
    input  cmd_valid, cmd_addr, rsp_ready, ip_dat, ip_trans_id,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, busy, ip_addr, ip_req_trans
  );

  modport slave (
    output cmd_valid, cmd_addr, rsp_ready, ip_dat, ip_trans_id,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, busy, ip_addr, ip_req_trans
  );
endinterface

// File: rtl/ip_txn_requester.sv
// Tagged read requester for one system-agent port: command FIFO, single outstanding request.
// Optional WAIT timeout with retry/error completion when IPREQ_TIMEOUT_EN is defined.
module ip_txn_requester #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ip_txn_requester_if.master    bus
);

  localparam int unsigned PtrW = $clog2(CMD_DEPTH);

  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("CMD_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end
  if (MAX_RETRY > 255) begin : g_bad_retry
    $error("MAX_RETRY must fit in 8 bits");
  end

`ifdef IPREQ_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StWait, StRetry, StResp} state_e;
  localparam int unsigned CntW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
  localparam logic [7:0]      MaxRetry    = 8'(MAX_RETRY);
`else
  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
`endif

  // Command FIFO
  logic [15:0]     fifo_q [CMD_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            push, pop;

  state_e      state_q;
  logic [3:0]  tag_q, tag_next;
  logic [15:0] ip_addr_q;
  logic [5:0]  ip_req_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic [15:0] rsp_addr_q;
  logic        match;
`ifdef IPREQ_TIMEOUT_EN
  logic            rsp_err_q;
  logic [CntW-1:0] wait_cnt_q;
  logic [7:0]      retry_q;
`endif

  assign bus.cmd_ready = (count_q != (PtrW + 1)'(CMD_DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state_q == StIdle) && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= bus.cmd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag 0 means "no completion" on ip_trans_id, so the counter skips it.
  assign tag_next = (tag_q == 4'd15) ? 4'd1 : tag_q + 4'd1;
  assign match    = (bus.ip_trans_id == tag_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tag_q       <= 4'd1;
      ip_addr_q   <= '0;
      ip_req_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
`ifdef IPREQ_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
      retry_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            ip_addr_q  <= fifo_q[rd_ptr_q];
            rsp_addr_q <= fifo_q[rd_ptr_q];
            ip_req_q   <= {2'b10, tag_q};
            state_q    <= StWait;
`ifdef IPREQ_TIMEOUT_EN
            wait_cnt_q <= '0;
            retry_q    <= '0;
`endif
          end
        end
        StWait: begin
          if (match) begin
            rsp_data_q  <= bus.ip_dat;
            rsp_valid_q <= 1'b1;
            ip_req_q    <= '0;
            tag_q       <= tag_next;
            state_q     <= StResp;
`ifdef IPREQ_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (wait_cnt_q == TimeoutLast) begin
            ip_req_q <= '0;
            tag_q    <= tag_next;
            if (retry_q < MaxRetry) begin
              retry_q <= retry_q + 8'd1;
              state_q <= StRetry;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              state_q     <= StResp;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
          end
        end
`ifdef IPREQ_TIMEOUT_EN
        StRetry: begin
          // Same address, tag already advanced at the timeout edge.
          ip_req_q   <= {2'b10, tag_q};
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
`endif
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ip_addr      = ip_addr_q;
  assign bus.ip_req_trans = ip_req_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_addr     = rsp_addr_q;
  assign bus.busy         = (count_q != '0) || (state_q != StIdle);
`ifdef IPREQ_TIMEOUT_EN
  assign bus.rsp_err      = rsp_err_q;
`else
  assign bus.rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ip_txn_requester.sv
// Scoreboard bench for ip_txn_requester: expected responses queued at command push,
// checked when the DUT presents them; a small agent model answers requests.
module tb_ip_txn_requester;

  localparam int unsigned CmdDepth = 4;
  localparam int unsigned Timeout  = 8;
  localparam int unsigned MaxRetry = 2;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } agent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ip_txn_requester_if bus ();

  ip_txn_requester #(
    .CMD_DEPTH (CmdDepth),
    .TIMEOUT   (Timeout),
    .MAX_RETRY (MaxRetry)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t   sb[$];
  agent_t aq[$];
  int     n_cmp = 0;
  int     n_err = 0;
  logic [3:0] model_tag = 4'd1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] next_tag(input logic [3:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

  task automatic push(input logic [15:0] a, input logic [31:0] d, input bit acc, input bit err);
    bus.cmd_addr  = a;
    bus.cmd_valid = 1'b1;
    check_eq("cmd_ready", bus.cmd_ready, acc);
    tick();
    bus.cmd_valid = 1'b0;
    if (acc) begin
      sb.push_back('{addr: a, data: (err ? 32'h0 : d), err: err});
      aq.push_back('{addr: a, data: d});
    end
  endtask

  task automatic serve(input int dly);
    agent_t a;
    int n = 0;
    while (!bus.ip_req_trans[5] && n < 50) begin
      tick();
      n++;
    end
    check_eq("req_seen", bus.ip_req_trans[5], 1'b1);
    check_eq("agent_q_nonempty", aq.size() != 0, 1'b1);
    if (aq.size() == 0) return;
    a = aq.pop_front();
    check_eq("req_trans", bus.ip_req_trans, {2'b10, model_tag});
    check_eq("req_addr", bus.ip_addr, a.addr);
    repeat (dly) tick();
    check_eq("req_hold", bus.ip_req_trans, {2'b10, model_tag});
    bus.ip_trans_id = model_tag;
    bus.ip_dat      = a.data;
    tick();
    bus.ip_trans_id = 4'd0;
    bus.ip_dat      = 32'h0;
    check_eq("req_drop", bus.ip_req_trans, 6'b0);
    check_eq("rsp_valid_up", bus.rsp_valid, 1'b1);
    model_tag = next_tag(model_tag);
  endtask

  task automatic take_rsp();
    exp_t e;
    int n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq("rsp_seen", bus.rsp_valid, 1'b1);
    check_eq("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    tick();
    check_eq("rsp_hold_valid", bus.rsp_valid, 1'b1);
    check_eq("rsp_data", bus.rsp_data, e.data);
    check_eq("rsp_addr", bus.rsp_addr, e.addr);
    check_eq("rsp_err", bus.rsp_err, e.err);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_eq("rsp_cleared", bus.rsp_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    aq.delete();
    model_tag = 4'd1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_addr    = 16'h0;
    bus.rsp_ready   = 1'b0;
    bus.ip_dat      = 32'h0;
    bus.ip_trans_id = 4'd0;

    // Reset values
    tick();
    tick();
    check_eq("rst_req", bus.ip_req_trans, 6'b0);
    check_eq("rst_addr", bus.ip_addr, 16'h0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("rst_rsp_data", bus.rsp_data, 32'h0);
    check_eq("rst_rsp_addr", bus.rsp_addr, 16'h0);
    check_eq("rst_rsp_err", bus.rsp_err, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_cmd_ready", bus.cmd_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Single read with exact latency
    push(16'h0010, 32'hCAFE_0001, 1'b1, 1'b0);
    check_eq("single_not_yet", bus.ip_req_trans, 6'b0);
    tick();
    check_eq("single_req", bus.ip_req_trans, 6'b100001);
    check_eq("single_busy", bus.busy, 1'b1);
    serve(1);
    take_rsp();
    check_eq("single_idle_busy", bus.busy, 1'b0);

    // FIFO full / backpressure, agent silent while filling
    for (int i = 0; i < 5; i++) begin
      push(16'h0020 + 16'(i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
    end
    push(16'h00FF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("full_busy", bus.busy, 1'b1);
    serve(0);
    take_rsp();
    check_eq("idle_gap", bus.ip_req_trans, 6'b0);
    tick();
    check_eq("b2b_issue", bus.ip_req_trans[5], 1'b1);
    for (int i = 1; i < 5; i++) begin
      serve(i % 2);
      take_rsp();
    end
    check_eq("fifo_drained", bus.busy, 1'b0);

    // Asynchronous reset mid-WAIT
    push(16'h0ABC, 32'h0BAD_0BAD, 1'b1, 1'b0);
    tick();
    check_eq("pre_rst_req", bus.ip_req_trans[5], 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_req", bus.ip_req_trans, 6'b0);
    check_eq("arst_addr", bus.ip_addr, 16'h0);
    check_eq("arst_rsp_data", bus.rsp_data, 32'h0);
    check_eq("arst_rsp_addr", bus.rsp_addr, 16'h0);
    check_eq("arst_busy", bus.busy, 1'b0);
    check_eq("arst_cmd_ready", bus.cmd_ready, 1'b1);
    do_reset();

    // Tag wrap: 15 reads then a 16th with a stray tag injected
    for (int i = 0; i < 15; i++) begin
      push(16'h0100 + 16'(i), 32'hD000_0000 + 32'(i), 1'b1, 1'b0);
      serve(i % 3);
      take_rsp();
    end
    push(16'h0200, 32'h1234_5678, 1'b1, 1'b0);
    tick();
    check_eq("wrap_tag", bus.ip_req_trans, 6'b100001);
    bus.ip_trans_id = 4'd7;
    bus.ip_dat      = 32'hDEAD_BEEF;
    tick();
    bus.ip_trans_id = 4'd0;
    bus.ip_dat      = 32'h0;
    check_eq("stray_tag_req", bus.ip_req_trans, 6'b100001);
    check_eq("stray_tag_rsp", bus.rsp_valid, 1'b0);
    serve(0);
    take_rsp();

`ifdef IPREQ_TIMEOUT_EN
    // Timeout with retries, then error completion
    do_reset();
    push(16'h0300, 32'h0, 1'b1, 1'b1);
    void'(aq.pop_front());
    tick();
    check_eq("to_issue", bus.ip_req_trans, {2'b10, model_tag});
    for (int r = 0; r <= int'(MaxRetry); r++) begin
      repeat (Timeout - 1) tick();
      check_eq("to_still_req", bus.ip_req_trans, {2'b10, model_tag});
      tick();
      model_tag = next_tag(model_tag);
      check_eq("to_drop", bus.ip_req_trans, 6'b0);
      if (r < int'(MaxRetry)) begin
        check_eq("to_retry_no_rsp", bus.rsp_valid, 1'b0);
        tick();
        check_eq("to_reissue", bus.ip_req_trans, {2'b10, model_tag});
        check_eq("to_reissue_addr", bus.ip_addr, 16'h0300);
      end else begin
        check_eq("to_err_valid", bus.rsp_valid, 1'b1);
        check_eq("to_err_flag", bus.rsp_err, 1'b1);
      end
    end
    take_rsp();

    // Match on the timeout edge wins
    push(16'h0301, 32'h5555_AAAA, 1'b1, 1'b0);
    serve(int'(Timeout) - 1);
    take_rsp();
    tick();
    check_eq("collide_no_retry", bus.ip_req_trans, 6'b0);
    check_eq("collide_idle", bus.busy, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
